// File: rtl/fu_mult_wb_buf_pkg.sv
// Shared defines and types for the multiplier write-back buffer.
// Holds the machine-wide widths and the packed buffer entry layout.

`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif

`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif

`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

`ifndef ZERO_REG
`define ZERO_REG {`PRF_IDX_W{1'b0}}
`endif

package fu_mult_wb_buf_pkg;

    localparam int ROB_IDX_W = `ROB_IDX_W;
    localparam int PRF_IDX_W = `PRF_IDX_W;
    localparam int BR_MASK_W = `BR_MASK_W;
    localparam int PRODUCT_W = 64;

    typedef logic [BR_MASK_W-1:0] br_mask_t;

    // One buffered multiplier result waiting for the CDB.
    typedef struct packed {
        logic [PRODUCT_W-1:0] product;
        logic [ROB_IDX_W:0]   rob_idx;
        logic [PRF_IDX_W-1:0] dest_tag;
        br_mask_t             br_mask;
    } mult_entry_t;

    // True when a result depends on the branch named by the one-hot fix tag.
    function automatic logic mask_hit(input br_mask_t mask, input br_mask_t fix);
        return |(mask & fix);
    endfunction

    // Drop the resolving branch from a dependency mask when it was predicted correctly.
    function automatic br_mask_t mask_resolve(input br_mask_t mask, input br_mask_t fix,
                                              input logic correct);
        return correct ? (mask & ~fix) : mask;
    endfunction

endpackage

// File: rtl/fu_mult_wb_buf.sv
// Result buffer between the multiplier's last stage and the CDB.
// Results queue in push order, are squashed on mispredicts, have their branch
// masks trimmed on correct predictions, and stall the multiplier when full.

`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif

`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif

`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

`ifndef ZERO_REG
`define ZERO_REG {`PRF_IDX_W{1'b0}}
`endif

module fu_mult_wb_buf
    import fu_mult_wb_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  mult_done_i,
    input  logic [63:0]           mult_product_i,
    input  logic [`ROB_IDX_W:0]   mult_rob_idx_i,
    input  logic [`PRF_IDX_W-1:0] mult_dest_tag_i,
    input  logic [`BR_MASK_W-1:0] mult_br_mask_i,

    input  logic                  rob_br_recovery_i,
    input  logic                  rob_br_pred_correct_i,
    input  logic [`BR_MASK_W-1:0] rob_br_tag_fix_i,

    input  logic                  cdb_gnt_i,

    output logic                  stall_o,
    output logic                  cdb_req_o,
    output logic [63:0]           cdb_value_o,
    output logic [`ROB_IDX_W:0]   cdb_rob_idx_o,
    output logic [`PRF_IDX_W-1:0] cdb_dest_tag_o,
    output logic [`BR_MASK_W-1:0] cdb_br_mask_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_next;
    mult_entry_t      entries [DEPTH];

    mult_entry_t head_entry;
    mult_entry_t push_entry;
    br_mask_t    head_mask_resolved;
    logic        occupied;
    logic        head_squash;
    logic        incoming_squash;
    logic        push;
    logic        pop;
    logic        bubble;
    logic        retire;

    // Full flag comes straight from the registered count so the multiplier stall has no input paths.
    assign stall_o = (count == FULL_COUNT);

    // Decode this cycle's push, pop and bubble-retire decisions from state and inputs.
    always_comb begin
        occupied           = (count != '0);
        head_entry         = entries[head];
        head_squash        = rob_br_recovery_i && mask_hit(head_entry.br_mask, rob_br_tag_fix_i);
        head_mask_resolved = mask_resolve(head_entry.br_mask, rob_br_tag_fix_i,
                                          rob_br_pred_correct_i);

        cdb_req_o = occupied && valid[head] && !head_squash;
        pop       = cdb_req_o && cdb_gnt_i;
        bubble    = occupied && !valid[head];
        retire    = pop || bubble;

        incoming_squash = rob_br_recovery_i && mask_hit(mult_br_mask_i, rob_br_tag_fix_i);
        push            = mult_done_i && !stall_o && !incoming_squash;

        push_entry.product  = mult_product_i;
        push_entry.rob_idx  = mult_rob_idx_i;
        push_entry.dest_tag = mult_dest_tag_i;
        push_entry.br_mask  = mask_resolve(mult_br_mask_i, rob_br_tag_fix_i,
                                           rob_br_pred_correct_i);
    end

    // Head entry drives the broadcast; tag and mask are forced idle when nothing is requested.
    always_comb begin
        cdb_value_o    = head_entry.product;
        cdb_rob_idx_o  = head_entry.rob_idx;
        cdb_dest_tag_o = cdb_req_o ? head_entry.dest_tag : `ZERO_REG;
        cdb_br_mask_o  = cdb_req_o ? head_mask_resolved : '0;
    end

    // Next valid bits: squash dependents, retire the popped head, then mark the new tail entry.
    always_comb begin
        valid_next = valid;
        for (int i = 0; i < DEPTH; i++) begin
            if (rob_br_recovery_i && mask_hit(entries[i].br_mask, rob_br_tag_fix_i)) begin
                valid_next[i] = 1'b0;
            end
        end
        if (pop) begin
            valid_next[head] = 1'b0;
        end
        if (push) begin
            valid_next[tail] = 1'b1;
        end
    end

    // Pointer, occupancy and valid-bit state; squashed slots stay counted until bubble-retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            valid <= valid_next;
            if (retire) begin
                head <= head + PTR_ONE;
            end
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (push && !retire) begin
                count <= count + CNT_ONE;
            end else if (retire && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Payload storage: write the pushed result and trim masks of every stored result on a correct prediction.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (tail == PTR_W'(i))) begin
                entries[i] <= push_entry;
            end else if (rob_br_pred_correct_i) begin
                entries[i].br_mask <= entries[i].br_mask & ~rob_br_tag_fix_i;
            end
        end
    end

endmodule

// File: doc/fu_mult_wb_buf.md
FU_MULT_WB_BUF -- requirements
Module: fu_mult_wb_buf

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving result-buffer entries (power of two, at least 2).
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 mult_done_i  input  1  the multiplier's final stage holds a valid result.
REQ-005 mult_product_i  input  64  the multiplier's final-stage product.
REQ-006 mult_rob_idx_i  input  `ROB_IDX_W+1  ROB index of the result.
REQ-007 mult_dest_tag_i  input  `PRF_IDX_W  destination physical register.
REQ-008 mult_br_mask_i  input  `BR_MASK_W  branch dependency mask of the result.
REQ-009 rob_br_recovery_i  input  1  branch mispredict recovery this cycle.
REQ-010 rob_br_pred_correct_i  input  1  branch resolved as correctly predicted this cycle.
REQ-011 rob_br_tag_fix_i  input  `BR_MASK_W  one-hot tag of the resolving branch.
REQ-012 cdb_gnt_i  input  1  CDB arbiter grant for this unit.
REQ-013 stall_o  output  1  drives the multiplier stall_i; holds the whole multiplier pipeline.
REQ-014 cdb_req_o  output  1  request to broadcast the head entry.
REQ-015 cdb_value_o  output  64  head product.
REQ-016 cdb_rob_idx_o  output  `ROB_IDX_W+1  head ROB index.
REQ-017 cdb_dest_tag_o  output  `PRF_IDX_W  head destination tag; `ZERO_REG when cdb_req_o is 0.
REQ-018 cdb_br_mask_o  output  `BR_MASK_W  head branch mask after same-cycle correct-prediction clearing.

Function
REQ-019 Storage SHALL be a circular buffer with head pointer, tail pointer, occupancy count (0..DEPTH), and per-entry valid bit.
REQ-020 stall_o SHALL equal (count == DEPTH), be derived from registered state only, and have no combinational path from cdb_gnt_i or mult_done_i.
REQ-021 Push: mult_done_i && !stall_o SHALL write the input at the tail, set its valid bit, advance the tail, and increment count.
REQ-021a Exception: on a cycle with rob_br_recovery_i and (mult_br_mask_i & rob_br_tag_fix_i) != 0, the input SHALL be dropped (no write, no increment).
REQ-022 While stall_o=1, a held mult_done_i SHALL NOT be captured; the same result SHALL be captured once on the first cycle stall_o=0.
REQ-023 cdb_req_o SHALL be count>0 && valid[head] && !(rob_br_recovery_i && (mask[head] & rob_br_tag_fix_i) != 0).
REQ-024 Pop: cdb_req_o && cdb_gnt_i SHALL clear valid[head], advance the head, and decrement count.
REQ-024a cdb_gnt_i without cdb_req_o SHALL be ignored.
REQ-025 Bubble retire: count>0 && !valid[head] SHALL advance the head and decrement count without a request, one bubble per cycle.
REQ-026 Squash: rob_br_recovery_i SHALL clear the valid bit of every entry with (mask & rob_br_tag_fix_i) != 0; count is unchanged (REQ-025 reclaims these slots).
REQ-027 Correct prediction: rob_br_pred_correct_i SHALL clear the rob_br_tag_fix_i bit in every stored mask and in a same-cycle pushed mask.
REQ-027a cdb_br_mask_o SHALL reflect the cleared value in that same cycle.
REQ-028 Simultaneous push and pop/bubble-retire SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-029 Latency: a result pushed at edge N SHALL be presented with cdb_req_o=1 in the cycle after edge N (no bypass).
REQ-030 Ordering: surviving entries SHALL be broadcast in push order.
REQ-031 Data outputs SHALL be driven from the head entry; cdb_value_o and cdb_rob_idx_o are don't-care when cdb_req_o=0.

Reset
REQ-032 rst_n=0 SHALL asynchronously set head=tail=0, count=0 and all valid bits 0, giving stall_o=0, cdb_req_o=0, cdb_dest_tag_o=`ZERO_REG and cdb_br_mask_o=0.
REQ-033 Reset mid-operation SHALL discard all entries, including any held multiplier result; entry payload registers need no reset.

Structure
REQ-034 `ROB_IDX_W, `PRF_IDX_W, `BR_MASK_W and `ZERO_REG SHALL come from the shared defines package.
REQ-034a A packed entry typedef (product, rob_idx, dest_tag, br_mask) SHALL be added to the shared package.
REQ-035 The module SHALL be flat with no sub-modules; the multiplier instantiates separately and connects stall_o to its stall_i.

Verification
REQ-036 Single result: push product 0x1234, dest tag 5, gnt held 1 -> req and tag 5 the next cycle, popped at that edge, count back to 0.
REQ-037 Fill: DEPTH=4, gnt=0, 5 back-to-back done pulses -> stall_o=1 after the 4th push; 5th held and captured exactly once the cycle after the first grant.
REQ-038 Squash: entries with masks 0b01, 0b10, 0b01; recovery with tag_fix=0b01 -> only the 0b10 entry broadcasts; count reaches 0 after the bubble retires.
REQ-039 Correct prediction: stored mask 0b11, pred_correct with tag_fix=0b10 -> cdb_br_mask_o=0b01 in the same cycle and thereafter.
REQ-040 Same-cycle recovery on head with gnt=1 -> cdb_req_o=0 and no broadcast; an incoming matching push is dropped.
REQ-041 Async reset asserted with 3 entries between clock edges -> outputs reach reset values immediately, and nothing broadcasts after release.
